// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer for the 32-bit shifter stages (16/8/4/2/1).
// One stage is applied per clock, most-significant shamt bit first.
// Handshake: start/ready request, one-cycle result_valid pulse in DONE.
module shift_seq_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter bit ZERO_FAST   = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic                   flush,
    output logic                   ready,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   result_valid,
    output logic                   err
);

    localparam int KW = (SHAMT_WIDTH > 1) ? $clog2(SHAMT_WIDTH) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(SHAMT_WIDTH - 1);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [SHAMT_WIDTH-1:0] shamt_q, shamt_d;
    logic [DATA_WIDTH-1:0]  wr_q, wr_d;
    logic [KW-1:0]          k_q, k_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;

    logic                   accept;
    logic [SHAMT_WIDTH-1:0] stage_amt;
    logic [DATA_WIDTH-1:0]  stage_out;

    assign accept = (state_q == IDLE) && start && !flush;

    // One shifter stage: shifts wr by 2^k when shamt[k] is set, otherwise passes it through.
    always_comb begin
        stage_amt = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1} << k_q;
        stage_out = wr_q;
        if (shamt_q[k_q]) begin
            case (op_q)
                OP_SLL:  stage_out = wr_q << stage_amt;
                OP_SRL:  stage_out = wr_q >> stage_amt;
                OP_SRA:  stage_out = DATA_WIDTH'($signed(wr_q) >>> stage_amt);
                default: stage_out = wr_q;   // illegal op leaves the operand untouched
            endcase
        end
    end

    // Next-state and datapath update; flush drops any in-flight op without touching result.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        shamt_d  = shamt_q;
        wr_d     = wr_q;
        k_d      = k_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = op;
                    shamt_d = shamt;
                    wr_d    = data_in;
                    if (ZERO_FAST && ((shamt == '0) || (op == OP_ILL))) begin
                        result_d = data_in;
                        state_d  = DONE;
                    end else begin
                        k_d     = K_TOP;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    wr_d = stage_out;
                    if (k_q == '0) begin
                        result_d = stage_out;
                        state_d  = DONE;
                    end else begin
                        k_d = k_q - 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            shamt_q  <= '0;
            wr_q     <= '0;
            k_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            shamt_q  <= shamt_d;
            wr_q     <= wr_d;
            k_q      <= k_d;
            result_q <= result_d;
        end
    end

    assign ready        = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign err          = (state_q == DONE) && (op_q == OP_ILL);
    assign result       = result_q;

endmodule
